// File: rtl/fp_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : fp_issue_wb
// Description : Issue and writeback sequencer for the FP unit. Accepts one op
//               per cycle, schedules fixed-latency results by tag, tracks one
//               iterative fdiv/fsqrt, and emits one registered writeback per
//               cycle in completion order.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_issue_wb #(
  parameter int TAG_W    = 5,
  parameter int MISC_LAT = 1,
  parameter int FMA_LAT  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  input  logic [TAG_W-1:0] req_tag,
  output logic             exe_enable,
  input  logic [63:0]      res_data,
  input  logic [4:0]       res_flags,
  input  logic             div_ready,
  input  logic [63:0]      div_data,
  input  logic [4:0]       div_flags,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [63:0]      wb_data,
  output logic [4:0]       wb_flags,
  output logic             busy
);

  localparam logic [1:0] C_CLS_FMA = 2'd1;
  localparam logic [1:0] C_CLS_DIV = 2'd2;

  // Schedule: slot k valid means its result shows up on res_* in k cycles.
  logic [FMA_LAT-1:0] r_slot_vld;
  logic [TAG_W-1:0]   r_slot_tag [FMA_LAT];
  logic [FMA_LAT-1:0] w_slot_vld_nxt;
  logic [TAG_W-1:0]   w_slot_tag_nxt [FMA_LAT];

  logic               r_div_busy;
  logic [TAG_W-1:0]   r_div_tag;
  logic               r_hold_vld;
  logic [TAG_W-1:0]   r_hold_tag;
  logic [63:0]        r_hold_data;
  logic [4:0]         r_hold_flags;

  logic               r_wb_vld;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [63:0]        r_wb_data;
  logic [4:0]         r_wb_flags;

  logic w_is_fma;
  logic w_is_div;
  logic w_misc_free;
  logic w_div_done;

  assign w_is_fma   = (req_class == C_CLS_FMA);
  assign w_is_div   = (req_class == C_CLS_DIV);
  // Stale div_ready strobes (e.g. after reset) are ignored when nothing is tracked.
  assign w_div_done = r_div_busy & div_ready;

  // A misc op lands in slot MISC_LAT-1 after the shift, so it collides with
  // whatever currently sits in slot MISC_LAT.
  generate
    if (MISC_LAT == FMA_LAT) begin : g_misc_nochk
      assign w_misc_free = 1'b1;
    end else begin : g_misc_chk
      assign w_misc_free = ~r_slot_vld[MISC_LAT];
    end
  endgenerate

  // Per-class acceptance; forced low while reset is asserted.
  always_comb begin
    req_ready = 1'b0;
    if (reset && !r_hold_vld) begin
      if (w_is_div)      req_ready = ~r_div_busy;
      else if (w_is_fma) req_ready = 1'b1;
      else               req_ready = w_misc_free;
    end
  end

  assign exe_enable = req_valid & req_ready;

  // Shift the schedule down one slot and insert a newly accepted fixed-latency op.
  always_comb begin
    w_slot_vld_nxt = r_slot_vld >> 1;
    for (int k = 0; k < FMA_LAT - 1; k++) begin
      w_slot_tag_nxt[k] = r_slot_tag[k+1];
    end
    w_slot_tag_nxt[FMA_LAT-1] = '0;
    if (exe_enable && !w_is_div) begin
      if (w_is_fma) begin
        w_slot_vld_nxt[FMA_LAT-1] = 1'b1;
        w_slot_tag_nxt[FMA_LAT-1] = req_tag;
      end else begin
        w_slot_vld_nxt[MISC_LAT-1] = 1'b1;
        w_slot_tag_nxt[MISC_LAT-1] = req_tag;
      end
    end
  end

  // Schedule, divider tracking, hold register and prioritised writeback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot_vld   <= '0;
      for (int k = 0; k < FMA_LAT; k++) r_slot_tag[k] <= '0;
      r_div_busy   <= 1'b0;
      r_div_tag    <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_tag   <= '0;
      r_hold_data  <= '0;
      r_hold_flags <= '0;
      r_wb_vld     <= 1'b0;
      r_wb_tag     <= '0;
      r_wb_data    <= '0;
      r_wb_flags   <= '0;
    end else begin
      r_slot_vld <= w_slot_vld_nxt;
      for (int k = 0; k < FMA_LAT; k++) r_slot_tag[k] <= w_slot_tag_nxt[k];

      // Class 2 is only accepted when no divide is tracked, so this never
      // coincides with a completion below.
      if (exe_enable && w_is_div) begin
        r_div_busy <= 1'b1;
        r_div_tag  <= req_tag;
      end

      if (r_slot_vld[0]) begin
        r_wb_vld   <= 1'b1;
        r_wb_tag   <= r_slot_tag[0];
        r_wb_data  <= res_data;
        r_wb_flags <= res_flags;
        // Fixed-latency result wins the port; park the divide result.
        if (w_div_done) begin
          r_hold_vld   <= 1'b1;
          r_hold_tag   <= r_div_tag;
          r_hold_data  <= div_data;
          r_hold_flags <= div_flags;
          r_div_busy   <= 1'b0;
        end
      end else if (r_hold_vld) begin
        r_wb_vld   <= 1'b1;
        r_wb_tag   <= r_hold_tag;
        r_wb_data  <= r_hold_data;
        r_wb_flags <= r_hold_flags;
        r_hold_vld <= 1'b0;
      end else if (w_div_done) begin
        r_wb_vld   <= 1'b1;
        r_wb_tag   <= r_div_tag;
        r_wb_data  <= div_data;
        r_wb_flags <= div_flags;
        r_div_busy <= 1'b0;
      end else begin
        r_wb_vld <= 1'b0;
      end
    end
  end

  assign wb_valid = r_wb_vld;
  assign wb_tag   = r_wb_tag;
  assign wb_data  = r_wb_data;
  assign wb_flags = r_wb_flags;
  assign busy     = (|r_slot_vld) | r_div_busy | r_hold_vld;

endmodule
`default_nettype wire

// File: doc/fp_issue_wb.md
Name: fp_issue_wb

Overview:
Issue and writeback sequencer wrapped around the floating-point unit.
- Accepts one FP operation per cycle from the core with a valid/ready handshake.
- Pulses the FP unit's execute enable on acceptance.
- Tracks in-flight operations by latency class: fixed-latency misc ops, pipelined FMA, iterative fdiv/fsqrt.
- Captures their results and presents exactly one registered writeback per cycle, tagged with the destination tag.

Parameters:
TAG_W, 5, width of destination tag carried with each op
MISC_LAT, 1, cycles from acceptance to result on res_* for class 0 ops (1..FMA_LAT-1)
FMA_LAT, 3, cycles from acceptance to result on res_* for class 1 ops (>= 2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  core presents an op
req_ready  out  1  block accepts the op this cycle
req_class  in  2  0 = misc, 1 = fma, 2 = fdiv/fsqrt, 3 = treated as misc
req_tag  in  TAG_W  destination tag
exe_enable  out  1  start strobe to the FP unit, equals req_valid & req_ready
res_data  in  64  fixed-latency result from the FP unit
res_flags  in  5  fixed-latency exception flags
div_ready  in  1  fdiv/fsqrt completion strobe
div_data  in  64  fdiv/fsqrt result, valid when div_ready
div_flags  in  5  fdiv/fsqrt flags, valid when div_ready
wb_valid  out  1  registered writeback valid
wb_tag  out  TAG_W  writeback tag
wb_data  out  64  writeback data
wb_flags  out  5  writeback flags
busy  out  1  any op in flight, or div result held

Behaviour:
Reset values:
- wb_valid, wb_tag, wb_data, wb_flags = 0.
- All schedule slots, div_busy and hold_valid = 0.
- req_ready = 0 while reset is asserted; exe_enable therefore 0.

Schedule register:
- Slots slot[0..FMA_LAT-1], each holding a valid bit and a tag. slot[k] valid means the result arrives on res_* in k cycles; slot[0] means this cycle.
- Every edge: slot[k] <= slot[k+1] for k < FMA_LAT-1; slot[FMA_LAT-1] <= empty, unless written by an acceptance.
- An op of latency L accepted at cycle t is written to slot[L-1], so its result is on res_* at cycle t+L.

req_ready, combinational:
- class 0/3: !hold_valid && (MISC_LAT == FMA_LAT || !slot[MISC_LAT].valid).
- class 1: !hold_valid. No collision is possible at FMA_LAT because slot[FMA_LAT] does not exist.
- class 2: !div_busy && !hold_valid.

Divider tracking:
- On class 2 acceptance: div_busy <= 1 and div_tag <= req_tag.
- div_ready is ignored while div_busy = 0 (covers stale completions after reset).

Writeback priority each cycle, registered at the next edge:
1. If slot[0].valid: wb <= {1, slot[0].tag, res_data, res_flags}. If div_ready is also asserted, the div result goes to the hold register (hold_valid <= 1, div_busy <= 0).
2. Else if hold_valid: wb <= hold contents; hold_valid <= 0.
3. Else if div_busy && div_ready: wb <= {1, div_tag, div_data, div_flags}; div_busy <= 0.
4. Else: wb_valid <= 0. wb_tag, wb_data and wb_flags retain their last values.

Hold register rules:
- While hold_valid = 1, no acceptance of any class.
- Slots therefore drain and hold writes back within FMA_LAT cycles. No starvation.

Other rules:
- Latency from res_* to wb_*: 1 cycle.
- Writebacks are in completion order, not issue order.
- No backpressure on writeback; the consumer must take wb_* every cycle.
- Reset mid-operation discards all in-flight tags and held results. The core re-issues them.
- busy = any slot valid | div_busy | hold_valid.

Test Plan:
1. Reset then idle: after reset release, req_valid=0 -> wb_valid=0, busy=0, req_ready=1 for every class.
2. FMA back-to-back: class 1 tags 1, 2, 3 at cycles 0, 1, 2 -> exe_enable high cycles 0-2; wb_valid at cycles 4, 5, 6 with tags 1, 2, 3 and wb_data equal to res_data sampled at cycles 3, 4, 5.
3. Slot collision: class 1 tag 4 at cycle 0, then class 0 tag 5 at cycle 2 (MISC_LAT=1, would land on cycle 3) -> req_ready=0 at cycle 2; accepted cycle 3; wb tag 4 at cycle 4, tag 5 at cycle 5.
4. Divider with collision: class 2 tag 7 at cycle 0; class 1 tag 8 at cycle 5; div_ready with div_data=0x3FF0000000000000 at cycle 8 -> wb tag 8 at cycle 9; req_ready=0 during cycle 9; wb tag 7 with 0x3FF0000000000000 at cycle 10.
5. Second div while busy: class 2 accepted, then class 2 requested -> req_ready=0 until div_ready is seen; a class 0 request in the same window is accepted.
6. Reset mid-flight: class 1 accepted, reset asserted next cycle, released, then div_ready pulse -> no wb_valid at any point, busy=0.
